// File: rtl/fact_pkg.sv
// Shared definitions for the factorial datapath.
//   WIDTH   : operand/result width used throughout the factorial datapath (64).
//   state_t : IDLE/BUSY/DONE handshake encoding. The factorial controller
//             decodes these same 2-bit codes, so their values are fixed.
package fact_pkg;

  localparam int unsigned WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_128bit.sv
// 128-bit accumulate adder for the sequential multiplier.
// Ports:
//   a, b : 128-bit addends
//   sum  : a + b, truncated to 128 bits. The multiplier never produces a
//          carry out of bit 127, so no carry port is provided.
module add_128bit (
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic [127:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/mul_64bit_seq.sv
// Sequential radix-2 shift-add multiplier with early termination. It computes
// op_a * op_b for the factorial loop and stops as soon as the remaining
// multiplier bits are all zero.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   op_start : start request, accepted only in IDLE or DONE
//   op_a     : multiplicand, captured on an accepted start
//   op_b     : multiplier, captured on an accepted start
//   busy     : high while an operation is in progress
//   op_done  : one-cycle pulse; result/ovf are valid from this cycle
//   result   : low WIDTH bits of the product, held until the next DONE
//   ovf      : set when the full product does not fit in WIDTH bits
module mul_64bit_seq
  import fact_pkg::*;
#(
  parameter int unsigned WIDTH = fact_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             op_done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] acc_next;

  add_128bit u_add (
    .a   (acc),
    .b   (mcand),
    .sum (acc_sum)
  );

  // Value acc takes on the current BUSY edge; also feeds result/ovf on the
  // edge that enters DONE so the final partial product is not lost.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) acc_next = acc_sum;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      op_done <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          op_done <= 1'b0;
          if (op_start) begin
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            acc    <= '0;
            state  <= BUSY;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          // Terminate once no set bits remain above the one consumed now.
          if (mplier[WIDTH-1:1] == '0) begin
            state   <= DONE;
            busy    <= 1'b0;
            op_done <= 1'b1;
            result  <= acc_next[WIDTH-1:0];
            ovf     <= |acc_next[2*WIDTH-1:WIDTH];
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          op_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_64bit_seq.sv
module tb_mul_64bit_seq;

  logic        clk;
  logic        reset_n;
  logic        op_start;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        busy;
  logic        op_done;
  logic [63:0] result;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  mul_64bit_seq #(.WIDTH(64)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_start (op_start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .op_done  (op_done),
    .result   (result),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Number of BUSY cycles expected: bit length of the multiplier, at least 1.
  function automatic int exp_latency(input logic [63:0] b);
    int l = 1;
    for (int i = 0; i < 64; i++) if (b[i]) l = i + 1;
    return l;
  endfunction

  // One full operation from an idle/done state; optionally pokes op_start
  // with junk operands while busy, which must be ignored.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        input bit poke, input string tag);
    logic [127:0] p;
    int exp_l;
    int n;
    p = {64'b0, a} * {64'b0, b};
    exp_l = exp_latency(b);
    @(negedge clk);
    op_a = a; op_b = b; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    op_a = {$urandom, $urandom};
    op_b = {$urandom, $urandom};
    chk({tag, ".busy_start"}, {127'b0, busy}, 128'd1);
    n = 0;
    while (!op_done && n < 70) begin
      op_start = poke && (n < exp_l - 1) && n[0];
      @(posedge clk); #1;
      n++;
    end
    op_start = 1'b0;
    chk({tag, ".latency"}, n, exp_l);
    chk({tag, ".done"}, {127'b0, op_done}, 128'd1);
    chk({tag, ".busy_done"}, {127'b0, busy}, 128'd0);
    chk({tag, ".result"}, {64'b0, result}, {64'b0, p[63:0]});
    chk({tag, ".ovf"}, {127'b0, ovf}, {127'b0, |p[127:64]});
    @(posedge clk); #1;
    chk({tag, ".done_fall"}, {127'b0, op_done}, 128'd0);
    chk({tag, ".result_hold"}, {64'b0, result}, {64'b0, p[63:0]});
  endtask

  initial begin
    logic [63:0] ra, rb;
    int n;
    reset_n = 1'b0; op_start = 1'b0; op_a = '0; op_b = '0;
    #12;
    chk("reset.busy", {127'b0, busy}, 128'd0);
    chk("reset.done", {127'b0, op_done}, 128'd0);
    chk("reset.result", {64'b0, result}, 128'd0);
    chk("reset.ovf", {127'b0, ovf}, 128'd0);
    @(negedge clk); reset_n = 1'b1;

    run_op(64'd5, 64'd4, 1'b0, "five_x_four");
    run_op(64'd121645100408832000, 64'd20, 1'b0, "fact20");
    run_op(64'd2432902008176640000, 64'd21, 1'b0, "fact21_ovf");
    run_op(64'h8000_0000_0000_0000, 64'd2, 1'b0, "pow63_x2");
    run_op(64'd1, 64'h8000_0000_0000_0000, 1'b0, "max_latency");
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "all_ones");
    run_op(64'h1234_5678_9ABC_DEF0, 64'd1, 1'b0, "by_one");

    // Back-to-back: op_b=0, then a start held during DONE.
    @(negedge clk);
    op_a = 64'd77; op_b = 64'd0; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    @(posedge clk); #1;
    chk("b2b.zero_done", {127'b0, op_done}, 128'd1);
    chk("b2b.zero_result", {64'b0, result}, 128'd0);
    chk("b2b.zero_ovf", {127'b0, ovf}, 128'd0);
    op_a = 64'd3; op_b = 64'd3; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    chk("b2b.rebusy", {127'b0, busy}, 128'd1);
    chk("b2b.done_low", {127'b0, op_done}, 128'd0);
    n = 0;
    while (!op_done && n < 70) begin @(posedge clk); #1; n++; end
    chk("b2b.latency", n, 2);
    chk("b2b.result", {64'b0, result}, 128'd9);

    // Busy-time start pulses are ignored.
    run_op(64'hDEAD_BEEF, 64'h0000_0100_0000_0000, 1'b1, "poke_ignored");

    // Randomized operands with varied multiplier bit lengths.
    for (int k = 0; k < 24; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (k % 4 == 0) ra = ra >> 40;
      run_op(ra, rb, k[0], $sformatf("rand%0d", k));
    end

    // Reset mid-BUSY discards the operation and clears held outputs.
    @(negedge clk);
    op_a = 64'hABCD; op_b = 64'h8000_0000_0000_0000; op_start = 1'b1;
    @(posedge clk); #1;
    op_start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("midrst.busy_before", {127'b0, busy}, 128'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst.busy", {127'b0, busy}, 128'd0);
    chk("midrst.done", {127'b0, op_done}, 128'd0);
    chk("midrst.result", {64'b0, result}, 128'd0);
    chk("midrst.ovf", {127'b0, ovf}, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst.stay_idle", {127'b0, busy}, 128'd0);
    @(negedge clk); reset_n = 1'b1;
    run_op(64'd6, 64'd7, 1'b0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
